if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk_i, input, 1 bit; the single clock, and every register updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit; the reset, which is synchronous and active-high.
REQ-004 SHALL have port stall_i, input, 1 bit; the hazard-unit stall, which holds the PC and the IF/ID register.
REQ-005 SHALL have port PCsrc_i, input, 2 bits; the ID redirect select: 00 = none, 01 = branch/jal, 10 = jalr, 11 = none.
REQ-006 SHALL have port pcPlusImm_i, input, 32 bits; the branch/jal target from ID.
REQ-007 SHALL have port regPlusImm_i, input, 32 bits; the jalr target from ID.
REQ-008 SHALL have port imem_req_o, output, 1 bit; the instruction-memory request.
REQ-009 SHALL have port imem_addr_o, output, 32 bits; the fetch address, equal to the PC.
REQ-010 SHALL have port imem_ready_i, input, 1 bit; a response pulse, honoured only while imem_req_o=1.
REQ-011 SHALL have port imem_rdata_i, input, 32 bits; the instruction word, valid when imem_ready_i=1.
REQ-012 SHALL have port instr_o, output, 32 bits; the IF/ID instruction, from which ID slices rs1/rs2/rd/op/funct3/Instr31_7.
REQ-013 SHALL have port PC_o, output, 32 bits; the IF/ID PC.
REQ-014 SHALL have port pcPlus4_o, output, 32 bits; the IF/ID PC+4.
REQ-015 SHALL have port fetchWait_o, output, 1 bit; high while the state is FETCH or DROP and no response has arrived this cycle.

Function
REQ-016 SHALL implement FSM states FETCH, HOLD and DROP; req/addr are held stable until ready; imem_req_o=1 in FETCH and DROP, 0 in HOLD.
REQ-017 SHALL define redirect as PCsrc_i ∈ {01,10} AND stall_i=0; during stall_i=1, PCsrc_i is ignored.
REQ-018 SHALL set the redirect target to pcPlusImm_i for 01, and to regPlusImm_i with bit 0 cleared for 10.
REQ-019 SHALL, on redirect in any state: PC <= target; IF/ID <= NOP (32'h0000_0013, PC_o/pcPlus4_o = 0); next state DROP if in FETCH without ready, otherwise FETCH.
REQ-020 SHALL, in FETCH with ready, stall_i=0 and no redirect: IF/ID <= {imem_rdata_i, PC, PC+4}; PC <= PC+4; remain in FETCH.
REQ-021 SHALL, in FETCH with ready and stall_i=1: latch imem_rdata_i into the hold buffer; go to HOLD; PC and IF/ID unchanged.
REQ-022 SHALL, in FETCH without ready: IF/ID <= NOP if stall_i=0, else unchanged; PC unchanged.
REQ-023 SHALL, in HOLD with stall_i=0 and no redirect: IF/ID <= {hold buffer, PC, PC+4}; PC <= PC+4; go to FETCH.
REQ-024 SHALL, in DROP: discard the response; go to FETCH on ready; IF/ID <= NOP unless stall_i=1; PC keeps the redirect target.
REQ-025 SHALL wrap PC+4 modulo 2^32 (32'hFFFF_FFFC -> 0) with no error indication.
REQ-026 SHALL give zero-wait latency: with ready tied high, one instruction enters IF/ID per cycle.

Reset
REQ-027 SHALL, when rst_i=1 at a clock edge: PC <= RESET_PC; state <= FETCH; instr_o <= NOP; PC_o <= 0; pcPlus4_o <= 0; hold buffer <= 0; perf counters <= 0.
REQ-028 SHALL force imem_req_o=0 while rst_i=1, and SHALL abandon any outstanding response when reset is asserted mid-request.

Configuration
REQ-029 SHALL, with IF_PERF_COUNTERS_EN defined, add 32-bit outputs fetchCount_o (count of instructions delivered to IF/ID) and waitCount_o (count of cycles with fetchWait_o=1), both wrapping.
REQ-030 SHALL, without IF_PERF_COUNTERS_EN, have neither those ports nor the counters, and SHALL otherwise behave identically.

Structure
REQ-031 SHALL place the NOP constant, the PCsrc encoding enum and the fetch-state enum in shared package pipeline_pkg.
REQ-032 SHALL isolate next-PC selection (PC+4, branch target, jalr target) in sub-module pc_next_mux.

Verification
REQ-033 SHALL check: reset with RESET_PC=32'h100 and ready tied 1 -> imem_addr_o = 100, 104, 108 on consecutive cycles, and PC_o trails by one cycle.
REQ-034 SHALL check: ready delayed 3 cycles -> fetchWait_o=1 for 3 cycles, NOP in IF/ID for those cycles, then the fetched word appears.
REQ-035 SHALL check: PCsrc_i=01 with pcPlusImm_i=32'h200 in FETCH without ready -> DROP; the late response is discarded; the next imem_addr_o is 200.
REQ-036 SHALL check: ready during stall_i=1 -> HOLD with imem_req_o=0; when the stall releases, the held word appears in instr_o and PC advances by 4.
REQ-037 SHALL check: PCsrc_i=10 with regPlusImm_i=32'h301 -> next fetch at 300; and PCsrc_i=01 during stall_i=1 -> ignored.
REQ-038 SHALL check: rst_i asserted while in DROP -> the next cycle fetches RESET_PC, instr_o=32'h13, and the counters read 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg -- definitions shared by the fetch stage and its neighbours.
//   NOP_INSTR    : canonical bubble (addi x0,x0,0)
//   pcsrc_e      : ID redirect select encoding
//   fetch_state_e: instruction-fetch FSM states
//   ifid_t       : contents of the IF/ID pipeline register
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    PCSRC_NONE   = 2'b00,
    PCSRC_BRANCH = 2'b01,  // branch / jal
    PCSRC_JALR   = 2'b10,
    PCSRC_NONE2  = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding, response goes to IF/ID
    ST_HOLD  = 2'd1,  // response captured during a stall, no request
    ST_DROP  = 2'd2   // request outstanding, response is stale
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

  localparam ifid_t IFID_NOP = '{instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux -- next-PC candidates for the fetch stage.
//   pc_i           : current PC
//   pcsrc_i        : ID redirect select
//   pc_plus_imm_i  : branch/jal target
//   reg_plus_imm_i : jalr target (bit 0 is cleared here)
//   pc_plus4_o     : sequential PC, wraps modulo 2^32
//   redir_sel_o    : pcsrc_i selects a redirect (stall qualification is the caller's job)
//   target_o       : redirect target
module pc_next_mux
  import pipeline_pkg::*;
(
  input  logic [31:0] pc_i,
  input  pcsrc_e      pcsrc_i,
  input  logic [31:0] pc_plus_imm_i,
  input  logic [31:0] reg_plus_imm_i,
  output logic [31:0] pc_plus4_o,
  output logic        redir_sel_o,
  output logic [31:0] target_o
);

  assign pc_plus4_o = pc_i + 32'd4;

  always_comb begin
    redir_sel_o = 1'b0;
    target_o    = pc_plus_imm_i;
    case (pcsrc_i)
      PCSRC_BRANCH: begin
        redir_sel_o = 1'b1;
        target_o    = pc_plus_imm_i;
      end
      PCSRC_JALR: begin
        redir_sel_o = 1'b1;
        target_o    = reg_plus_imm_i & ~32'h1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage with IF/ID register.
// Optional feature macro: IF_PERF_COUNTERS_EN (adds fetchCount_o / waitCount_o).
//   clk_i, rst_i        : clock, synchronous active-high reset
//   stall_i             : hazard stall, freezes PC and IF/ID
//   PCsrc_i             : 00/11 none, 01 branch/jal, 10 jalr
//   pcPlusImm_i         : branch/jal target
//   regPlusImm_i        : jalr target
//   imem_req_o/addr_o   : instruction memory request, address = PC
//   imem_ready_i/rdata_i: response pulse and data
//   instr_o/PC_o/pcPlus4_o : IF/ID register
//   fetchWait_o         : request outstanding with no response this cycle
module if_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic [1:0]  PCsrc_i,
  input  logic [31:0] pcPlusImm_i,
  input  logic [31:0] regPlusImm_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] PC_o,
  output logic [31:0] pcPlus4_o,
  output logic        fetchWait_o
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetchCount_o,
  output logic [31:0] waitCount_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  ifid_t        ifid_q, ifid_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redir_sel;
  logic         redirect;
  logic         rdy;
  logic         deliver;

  pc_next_mux u_pc_next_mux (
    .pc_i           (pc_q),
    .pcsrc_i        (pcsrc_e'(PCsrc_i)),
    .pc_plus_imm_i  (pcPlusImm_i),
    .reg_plus_imm_i (regPlusImm_i),
    .pc_plus4_o     (pc_plus4),
    .redir_sel_o    (redir_sel),
    .target_o       (target)
  );

  // Request is suppressed during reset so an in-flight response is ignored.
  assign imem_req_o  = ~rst_i & (state_q != ST_HOLD);
  assign imem_addr_o = pc_q;
  assign rdy         = imem_ready_i & imem_req_o;
  assign fetchWait_o = ((state_q == ST_FETCH) | (state_q == ST_DROP)) & ~rdy;
  assign redirect    = redir_sel & ~stall_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    ifid_d  = ifid_q;
    deliver = 1'b0;
    if (redirect) begin
      pc_d   = target;
      ifid_d = IFID_NOP;
      // An unanswered request must have its response discarded later.
      state_d = (state_q == ST_FETCH && !rdy) ? ST_DROP : ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (rdy) begin
            if (!stall_i) begin
              ifid_d  = '{instr: imem_rdata_i, pc: pc_q, pc4: pc_plus4};
              pc_d    = pc_plus4;
              deliver = 1'b1;
            end else begin
              hold_d  = imem_rdata_i;
              state_d = ST_HOLD;
            end
          end else if (!stall_i) begin
            ifid_d = IFID_NOP;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            ifid_d  = '{instr: hold_q, pc: pc_q, pc4: pc_plus4};
            pc_d    = pc_plus4;
            state_d = ST_FETCH;
            deliver = 1'b1;
          end
        end
        ST_DROP: begin
          if (rdy) state_d = ST_FETCH;
          if (!stall_i) ifid_d = IFID_NOP;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= 32'h0;
      ifid_q  <= IFID_NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      ifid_q  <= ifid_d;
    end
  end

  assign instr_o   = ifid_q.instr;
  assign PC_o      = ifid_q.pc;
  assign pcPlus4_o = ifid_q.pc4;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wait_cnt_q,  wait_cnt_d;

  assign fetch_cnt_d = fetch_cnt_q + {31'd0, deliver};
  assign wait_cnt_d  = wait_cnt_q + {31'd0, fetchWait_o};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= 32'h0;
      wait_cnt_q  <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign fetchCount_o = fetch_cnt_q;
  assign waitCount_o  = wait_cnt_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i, stall_i, imem_ready_i;
  logic [1:0]  PCsrc_i;
  logic [31:0] pcPlusImm_i, regPlusImm_i, imem_rdata_i;
  logic        imem_req_o, fetchWait_o;
  logic [31:0] imem_addr_o, instr_o, PC_o, pcPlus4_o;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetchCount_o, waitCount_o;
`endif

  int total = 0;
  int bad   = 0;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .PCsrc_i      (PCsrc_i),
    .pcPlusImm_i  (pcPlusImm_i),
    .regPlusImm_i (regPlusImm_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .PC_o         (PC_o),
    .pcPlus4_o    (pcPlus4_o),
    .fetchWait_o  (fetchWait_o)
`ifdef IF_PERF_COUNTERS_EN
    ,
    .fetchCount_o (fetchCount_o),
    .waitCount_o  (waitCount_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall;
    logic [1:0]  src;
    logic [31:0] pimm, rimm;
    logic        rdy;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr, einstr, epc, epc4;
    logic        efw;
  } vec_t;

  vec_t tv[26];

  function automatic vec_t v(logic rst, logic stall, logic [1:0] src, logic [31:0] pimm,
                             logic [31:0] rimm, logic rdy, logic [31:0] rdata, logic ereq,
                             logic [31:0] eaddr, logic [31:0] einstr, logic [31:0] epc,
                             logic [31:0] epc4, logic efw);
    vec_t r;
    r.rst = rst; r.stall = stall; r.src = src; r.pimm = pimm; r.rimm = rimm;
    r.rdy = rdy; r.rdata = rdata; r.ereq = ereq; r.eaddr = eaddr; r.einstr = einstr;
    r.epc = epc; r.epc4 = epc4; r.efw = efw;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic [1:0] src,
                       input logic [31:0] pimm, input logic [31:0] rimm,
                       input logic rdy, input logic [31:0] rdata);
    rst_i = rst; stall_i = stall; PCsrc_i = src; pcPlusImm_i = pimm;
    regPlusImm_i = rimm; imem_ready_i = rdy; imem_rdata_i = rdata;
  endtask

  initial begin
    // Inputs apply at the negedge and outputs are checked 1ns later;
    // expectations describe the cycle before the next rising edge.
    //            rst st src pimm          rimm          rdy rdata          req addr          instr          PC            PC+4          fw
    tv[0]  = v(0, 0, 2'b00, 0,            0,            1, 32'hA000_0001, 1, 32'h100,      NOP,           0,            0,            0);
    tv[1]  = v(0, 0, 2'b00, 0,            0,            1, 32'hA000_0002, 1, 32'h104,      32'hA000_0001, 32'h100,      32'h104,      0);
    tv[2]  = v(0, 0, 2'b00, 0,            0,            1, 32'hA000_0003, 1, 32'h108,      32'hA000_0002, 32'h104,      32'h108,      0);
    tv[3]  = v(0, 0, 2'b00, 0,            0,            0, 0,             1, 32'h10C,      32'hA000_0003, 32'h108,      32'h10C,      1);
    tv[4]  = v(0, 0, 2'b00, 0,            0,            0, 0,             1, 32'h10C,      NOP,           0,            0,            1);
    tv[5]  = v(0, 0, 2'b00, 0,            0,            0, 0,             1, 32'h10C,      NOP,           0,            0,            1);
    tv[6]  = v(0, 0, 2'b00, 0,            0,            1, 32'hB000_0001, 1, 32'h10C,      NOP,           0,            0,            0);
    tv[7]  = v(0, 0, 2'b00, 0,            0,            1, 32'hB000_0002, 1, 32'h110,      32'hB000_0001, 32'h10C,      32'h110,      0);
    tv[8]  = v(0, 0, 2'b01, 32'h200,      0,            0, 0,             1, 32'h114,      32'hB000_0002, 32'h110,      32'h114,      1);
    tv[9]  = v(0, 0, 2'b00, 0,            0,            1, 32'hDEAD_BEEF, 1, 32'h200,      NOP,           0,            0,            0);
    tv[10] = v(0, 0, 2'b00, 0,            0,            1, 32'hC000_0001, 1, 32'h200,      NOP,           0,            0,            0);
    tv[11] = v(0, 1, 2'b00, 0,            0,            1, 32'hC000_0002, 1, 32'h204,      32'hC000_0001, 32'h200,      32'h204,      0);
    tv[12] = v(0, 1, 2'b00, 0,            0,            1, 32'hBAD0_0001, 0, 32'h204,      32'hC000_0001, 32'h200,      32'h204,      0);
    tv[13] = v(0, 0, 2'b00, 0,            0,            0, 0,             0, 32'h204,      32'hC000_0001, 32'h200,      32'h204,      0);
    tv[14] = v(0, 0, 2'b00, 0,            0,            1, 32'hD000_0001, 1, 32'h208,      32'hC000_0002, 32'h204,      32'h208,      0);
    tv[15] = v(0, 0, 2'b10, 0,            32'h301,      1, 32'hD000_0002, 1, 32'h20C,      32'hD000_0001, 32'h208,      32'h20C,      0);
    tv[16] = v(0, 1, 2'b01, 32'h500,      0,            0, 0,             1, 32'h300,      NOP,           0,            0,            1);
    tv[17] = v(0, 0, 2'b00, 0,            0,            1, 32'hE000_0001, 1, 32'h300,      NOP,           0,            0,            0);
    tv[18] = v(0, 0, 2'b00, 0,            0,            0, 0,             1, 32'h304,      32'hE000_0001, 32'h300,      32'h304,      1);
    tv[19] = v(0, 0, 2'b01, 32'h400,      0,            0, 0,             1, 32'h304,      NOP,           0,            0,            1);
    tv[20] = v(1, 0, 2'b00, 0,            0,            1, 32'hBAD0_0002, 0, 32'h400,      NOP,           0,            0,            1);
    tv[21] = v(0, 0, 2'b00, 0,            0,            0, 0,             1, 32'h100,      NOP,           0,            0,            1);
    tv[22] = v(0, 0, 2'b01, 32'hFFFF_FFFC, 0,           1, 32'hF000_0000, 1, 32'h100,      NOP,           0,            0,            0);
    tv[23] = v(0, 0, 2'b00, 0,            0,            1, 32'hF000_0001, 1, 32'hFFFF_FFFC, NOP,          0,            0,            0);
    tv[24] = v(0, 0, 2'b00, 0,            0,            1, 32'hF000_0002, 1, 32'h0,        32'hF000_0001, 32'hFFFF_FFFC, 32'h0,       0);
    tv[25] = v(0, 0, 2'b00, 0,            0,            0, 0,             1, 32'h4,        32'hF000_0002, 32'h0,        32'h4,        1);

    // Reset: request forced low, reset state visible once an edge has passed.
    drive(1, 0, 2'b00, 0, 0, 1, 32'h1234_5678);
    @(negedge clk); #1;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    @(negedge clk); #1;
    chk("rst_addr",  imem_addr_o, RPC);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc",    PC_o, 32'h0);
    chk("rst_pc4",   pcPlus4_o, 32'h0);
`ifdef IF_PERF_COUNTERS_EN
    chk("rst_fcnt", fetchCount_o, 32'h0);
    chk("rst_wcnt", waitCount_o, 32'h0);
`endif

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].stall, tv[i].src, tv[i].pimm, tv[i].rimm, tv[i].rdy, tv[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i),   {31'd0, imem_req_o}, {31'd0, tv[i].ereq});
      chk($sformatf("v%0d_addr", i),  imem_addr_o, tv[i].eaddr);
      chk($sformatf("v%0d_instr", i), instr_o, tv[i].einstr);
      chk($sformatf("v%0d_pc", i),    PC_o, tv[i].epc);
      chk($sformatf("v%0d_pc4", i),   pcPlus4_o, tv[i].epc4);
      chk($sformatf("v%0d_fwait", i), {31'd0, fetchWait_o}, {31'd0, tv[i].efw});
`ifdef IF_PERF_COUNTERS_EN
      if (i == 21) begin
        chk("drop_rst_fcnt", fetchCount_o, 32'h0);
        chk("drop_rst_wcnt", waitCount_o, 32'h0);
      end
`endif
    end

    // Redirect while in HOLD: held word is discarded, fetch resumes at jalr target.
    @(negedge clk);
    drive(0, 1, 2'b00, 0, 0, 1, 32'h6000_0001);
    #1;
`ifdef IF_PERF_COUNTERS_EN
    // Delivered at v23, v24; waiting counted at v21, v25.
    chk("cnt_fetch", fetchCount_o, 32'd2);
    chk("cnt_wait",  waitCount_o, 32'd2);
`endif
    chk("h_addr", imem_addr_o, 32'h4);
    chk("h_req",  {31'd0, imem_req_o}, 32'd1);
    @(negedge clk);
    drive(0, 0, 2'b10, 0, 32'h601, 0, 0);
    #1;
    chk("h_req_hold", {31'd0, imem_req_o}, 32'd0);
    chk("h_instr",    instr_o, NOP);
    @(negedge clk);
    drive(0, 0, 2'b00, 0, 0, 1, 32'h7000_0001);
    #1;
    chk("h_redir_addr",  imem_addr_o, 32'h600);
    chk("h_redir_req",   {31'd0, imem_req_o}, 32'd1);
    chk("h_redir_instr", instr_o, NOP);
    @(negedge clk);
    drive(0, 0, 2'b00, 0, 0, 0, 0);
    #1;
    chk("h_new_instr", instr_o, 32'h7000_0001);
    chk("h_new_pc",    PC_o, 32'h600);
    chk("h_new_addr",  imem_addr_o, 32'h604);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
